// File: rtl/logic_gate_pkg.sv
// Shared op encoding for the bitwise logic unit and its pipelined wrapper.
package logic_gate_pkg;
  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_NOR  = 3'd0;
  localparam logic [OP_W-1:0] OP_OR   = 3'd1;
  localparam logic [OP_W-1:0] OP_AND  = 3'd2;
  localparam logic [OP_W-1:0] OP_NAND = 3'd3;
  localparam logic [OP_W-1:0] OP_XOR  = 3'd4;
  localparam logic [OP_W-1:0] OP_XNOR = 3'd5;
  localparam logic [OP_W-1:0] OP_NOTA = 3'd6;
  localparam logic [OP_W-1:0] OP_ILL  = 3'd7;

  function automatic logic is_legal_op(input logic [OP_W-1:0] op);
    return op != OP_ILL;
  endfunction
endpackage

// File: rtl/logic_gate_core.sv
// Combinational bitwise two-input logic unit; also used standalone.
module logic_gate_core
  import logic_gate_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [OP_W-1:0]  op_i,
  output logic [WIDTH-1:0] y_o,
  output logic             op_err_o
);
  always_comb begin
    y_o      = '0;
    op_err_o = !is_legal_op(op_i);
    case (op_i)
      OP_NOR:  y_o = ~(a_i | b_i);
      OP_OR:   y_o = a_i | b_i;
      OP_AND:  y_o = a_i & b_i;
      OP_NAND: y_o = ~(a_i & b_i);
      OP_XOR:  y_o = a_i ^ b_i;
      OP_XNOR: y_o = ~(a_i ^ b_i);
      OP_NOTA: y_o = ~a_i;
      default: y_o = '0;
    endcase
  end
endmodule

// File: rtl/logic_gate_pipe.sv
// Two-stage valid/ready pipeline around logic_gate_core: S1 holds operands,
// S2 holds the registered result, flags and drives the output handshake.
module logic_gate_pipe
  import logic_gate_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [OP_W-1:0]  op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             y_zero,
  output logic             op_err,
  output logic [CNT_W-1:0] xfer_cnt
);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic             s1_vld_q, s2_vld_q;
  logic [WIDTH-1:0] a_q, b_q, y_q;
  logic [OP_W-1:0]  op_q;
  logic             zero_q, err_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] core_y;
  logic             core_err;
  logic             s1_adv, s2_adv;

  // A stage may load when it is empty or its content moves on this edge.
  assign s2_adv   = !s2_vld_q || out_ready;
  assign s1_adv   = !s1_vld_q || s2_adv;
  assign in_ready = s1_adv;

  logic_gate_core #(.WIDTH(WIDTH)) u_core (
    .a_i      (a_q),
    .b_i      (b_q),
    .op_i     (op_q),
    .y_o      (core_y),
    .op_err_o (core_err)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
    end else if (s1_adv) begin
      s1_vld_q <= in_valid;
      if (in_valid) begin
        a_q  <= a;
        b_q  <= b;
        op_q <= op;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_vld_q <= 1'b0;
      y_q      <= '0;
      zero_q   <= 1'b1;
      err_q    <= 1'b0;
    end else if (s2_adv) begin
      s2_vld_q <= s1_vld_q;
      if (s1_vld_q) begin
        y_q    <= core_y;
        zero_q <= (core_y == '0);
        err_q  <= core_err;
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (s2_vld_q && out_ready && cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign out_valid = s2_vld_q;
  assign y         = y_q;
  assign y_zero    = zero_q;
  assign op_err    = err_q;
  assign xfer_cnt  = cnt_q;
endmodule

// File: tb/tb_logic_gate_pipe.sv
// Randomized bench for logic_gate_pipe: a truth-table reference and a FIFO
// scoreboard of expected results; a CNT_W=3 twin exercises counter saturation.
module tb_logic_gate_pipe;
  typedef struct {
    logic [7:0] y;
    logic       err;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic [7:0] a = '0, b = '0;
  logic [2:0] op = '0;
  logic       in_ready, out_valid, y_zero, op_err;
  logic [7:0] y;
  logic [15:0] xfer_cnt;
  logic       s_in_ready, s_out_valid, s_y_zero, s_op_err;
  logic [7:0] s_y;
  logic [2:0] s_xfer_cnt;

  int   n_cmp = 0, n_bad = 0;
  exp_t exp_q[$];
  logic [15:0] cnt_m = '0;
  logic [2:0]  cnt_s = '0;
  logic        pstall = 1'b0, pz = 1'b0, pe = 1'b0;
  logic [7:0]  py = '0;

  always #5 clk = ~clk;

  logic_gate_pipe #(.WIDTH(8), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .y_zero(y_zero), .op_err(op_err), .xfer_cnt(xfer_cnt)
  );

  logic_gate_pipe #(.WIDTH(8), .CNT_W(3)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
    .a(a), .b(b), .op(op), .out_valid(s_out_valid), .out_ready(out_ready),
    .y(s_y), .y_zero(s_y_zero), .op_err(s_op_err), .xfer_cnt(s_xfer_cnt)
  );

  // Each op as a 4-entry truth table indexed by {a_bit, b_bit}.
  function automatic exp_t ref_op(input logic [7:0] a_, input logic [7:0] b_, input logic [2:0] op_);
    logic [3:0] tt [0:7];
    exp_t r;
    tt = '{4'b0001, 4'b1110, 4'b1000, 4'b0111, 4'b0110, 4'b1001, 4'b0011, 4'b0000};
    for (int i = 0; i < 8; i++) r.y[i] = tt[op_][{a_[i], b_[i]}];
    r.err = (op_ == 3'd7);
    return r;
  endfunction

  function automatic void clear_model();
    exp_q.delete();
    cnt_m  = '0;
    cnt_s  = '0;
    pstall = 1'b0;
  endfunction

  // One clock: score the handshakes visible before the edge, then clock.
  task automatic cycle(output logic acc_in);
    logic acc_out;
    exp_t e;
    #1;
    acc_in  = in_valid && in_ready;
    acc_out = out_valid && out_ready;
    n_cmp++;
    if (in_ready !== ((exp_q.size() < 2) || out_ready)) begin
      n_bad++;
      $display("FAIL in_ready: got %b want %b (held %0d)", in_ready, (exp_q.size() < 2) || out_ready, exp_q.size());
    end
    if (pstall) begin
      n_cmp++;
      if (out_valid !== 1'b1 || y !== py || y_zero !== pz || op_err !== pe) begin
        n_bad++;
        $display("FAIL stall_hold: got v=%b y=%h z=%b e=%b want v=1 y=%h z=%b e=%b", out_valid, y, y_zero, op_err, py, pz, pe);
      end
    end
    if (out_valid === 1'b1) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL spurious_out: got out_valid=1 y=%h want no beat", y);
      end else begin
        e = exp_q[0];
        if (y !== e.y || op_err !== e.err || y_zero !== (e.y == 8'h00)) begin
          n_bad++;
          $display("FAIL result: got y=%h z=%b e=%b want y=%h z=%b e=%b", y, y_zero, op_err, e.y, e.y == 8'h00, e.err);
        end
      end
    end
    pstall = out_valid && !out_ready;
    py = y; pz = y_zero; pe = op_err;
    if (acc_out && exp_q.size() > 0) begin
      void'(exp_q.pop_front());
      if (cnt_m != 16'hFFFF) cnt_m++;
      if (cnt_s != 3'd7) cnt_s++;
    end
    if (acc_in) exp_q.push_back(ref_op(a, b, op));
    @(posedge clk);
    #1;
    n_cmp++;
    if (xfer_cnt !== cnt_m || s_xfer_cnt !== cnt_s) begin
      n_bad++;
      $display("FAIL xfer_cnt: got %0d/%0d want %0d/%0d", xfer_cnt, s_xfer_cnt, cnt_m, cnt_s);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || y !== 8'h00 || y_zero !== 1'b1 || op_err !== 1'b0 ||
        xfer_cnt !== 16'd0 || in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_state: got v=%b y=%h z=%b e=%b cnt=%0d rdy=%b want 0 00 1 0 0 1",
               out_valid, y, y_zero, op_err, xfer_cnt, in_ready);
    end
    rst_n = 1'b1;
    clear_model();
  endtask

  task automatic test_single();
    logic acc;
    a = 8'hF0; b = 8'h0F; op = 3'd0; in_valid = 1'b1; out_ready = 1'b1;
    cycle(acc);
    in_valid = 1'b0;
    n_cmp++;
    if (acc !== 1'b1 || out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL single_lat1: got acc=%b out_valid=%b want 1 0", acc, out_valid);
    end
    cycle(acc);
    n_cmp++;
    if (out_valid !== 1'b1 || y !== 8'h00 || y_zero !== 1'b1 || op_err !== 1'b0) begin
      n_bad++;
      $display("FAIL single_out: got v=%b y=%h z=%b e=%b want 1 00 1 0", out_valid, y, y_zero, op_err);
    end
    cycle(acc);
    n_cmp++;
    if (xfer_cnt !== 16'd1) begin
      n_bad++;
      $display("FAIL single_cnt: got %0d want 1", xfer_cnt);
    end
  endtask

  task automatic test_all_ops();
    logic [7:0] want [0:7];
    logic [7:0] got [0:7];
    logic       got_e [0:7];
    int n = 0, first = -1, last = -1;
    logic acc;
    want = '{8'h24, 8'hDB, 8'h42, 8'hBD, 8'h99, 8'h66, 8'h35, 8'h00};
    out_ready = 1'b1;
    for (int t = 0; t < 11; t++) begin
      in_valid = (t < 8);
      a = 8'hCA; b = 8'h53; op = 3'(t);
      cycle(acc);
      if (out_valid === 1'b1 && n < 8) begin
        got[n] = y; got_e[n] = op_err; n++;
        if (first < 0) first = t;
        last = t;
      end
    end
    in_valid = 1'b0;
    n_cmp++;
    if (n != 8 || last - first != 7) begin
      n_bad++;
      $display("FAIL ops_rate: got %0d beats over %0d cycles want 8 over 8", n, last - first + 1);
    end
    for (int k = 0; k < n; k++) begin
      n_cmp++;
      if (got[k] !== want[k] || got_e[k] !== (k == 7)) begin
        n_bad++;
        $display("FAIL ops_seq[%0d]: got y=%h e=%b want y=%h e=%b", k, got[k], got_e[k], want[k], k == 7);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] c0;
    logic acc;
    int i = 0, cyc = 0;
    c0 = xfer_cnt;
    a = 8'($urandom); b = 8'($urandom); op = 3'($urandom_range(0, 7)); in_valid = 1'b1;
    while (i < 5 && cyc < 50) begin
      out_ready = (cyc >= 4);
      if (cyc == 2) begin
        #1;
        n_cmp++;
        if (in_ready !== 1'b0) begin
          n_bad++;
          $display("FAIL bp_full: got in_ready=%b want 0", in_ready);
        end
      end
      cycle(acc);
      cyc++;
      if (acc) begin
        i++;
        a = 8'($urandom); b = 8'($urandom); op = 3'($urandom_range(0, 7));
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) cycle(acc);
    n_cmp++;
    if (i != 5 || xfer_cnt !== c0 + 16'd5 || exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL bp_total: got sent=%0d cnt=%0d left=%0d want 5 %0d 0", i, xfer_cnt, exp_q.size(), c0 + 16'd5);
    end
  endtask

  task automatic test_random();
    logic acc;
    int n = 0, cyc = 0;
    in_valid = 1'b0;
    while (n < 1000 && cyc < 6000) begin
      if (!in_valid && $urandom_range(0, 3) != 0) begin
        a = 8'($urandom); b = 8'($urandom); op = 3'($urandom_range(0, 7)); in_valid = 1'b1;
      end
      out_ready = ($urandom_range(0, 3) != 0);
      cycle(acc);
      cyc++;
      if (acc) begin
        n++;
        in_valid = 1'b0;
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) cycle(acc);
    n_cmp++;
    if (n != 1000 || exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL random_drain: got sent=%0d left=%0d want 1000 0", n, exp_q.size());
    end
  endtask

  task automatic test_saturation();
    logic acc;
    test_reset();
    out_ready = 1'b1;
    for (int t = 0; t < 10; t++) begin
      in_valid = 1'b1; a = 8'($urandom); b = 8'($urandom); op = 3'($urandom_range(0, 7));
      cycle(acc);
    end
    in_valid = 1'b0;
    repeat (3) cycle(acc);
    n_cmp++;
    if (s_xfer_cnt !== 3'd7 || xfer_cnt !== 16'd10) begin
      n_bad++;
      $display("FAIL saturate: got %0d/%0d want 7/10", s_xfer_cnt, xfer_cnt);
    end
  endtask

  task automatic test_reset_midflight();
    logic acc;
    out_ready = 1'b0; in_valid = 1'b1;
    for (int t = 0; t < 2; t++) begin
      a = 8'($urandom); b = 8'($urandom); op = 3'($urandom_range(0, 6));
      cycle(acc);
    end
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || xfer_cnt !== 16'd0 || y !== 8'h00 || y_zero !== 1'b1) begin
      n_bad++;
      $display("FAIL midflight_reset: got v=%b cnt=%0d y=%h z=%b want 0 0 00 1", out_valid, xfer_cnt, y, y_zero);
    end
    clear_model();
    @(posedge clk);
    #1;
    rst_n = 1'b1; out_ready = 1'b1;
    repeat (5) begin
      cycle(acc);
      n_cmp++;
      if (out_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL stale_beat: got out_valid=%b want 0", out_valid);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_ops();
    test_backpressure();
    test_random();
    test_saturation();
    test_reset_midflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
